// File: rtl/serial_input_port.sv
`default_nettype none
// ============================================================================
//  Module      : serial_input_port
//  Description : Serial-to-parallel input port for the SAP-II datapath.
//                Shifts a DATA_WIDTH-bit word in from a ready-qualified
//                serial stream, double-buffers the completed word in a
//                holding register and drives it onto the tri-state W bus
//                under Ei. Provides full/busy status, a one-cycle read
//                acknowledge and a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_input_port #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  ready,
    input  logic                  serial_in,
    input  logic                  Ei,
    output logic [DATA_WIDTH-1:0] WBUS,
    output logic                  full,
    output logic                  busy,
    output logic                  acknowledge,
    output logic                  overrun
);

    // Count value of the last bit of a word; sampling it completes the word.
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Shift path and bit counter
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    // Holding register and status flags
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] hold_d;
    logic                  full_q;
    logic                  full_d;
    logic                  overrun_q;
    logic                  overrun_d;
    logic                  ack_q;
    logic                  ack_d;

    // Combinational helpers
    logic [DATA_WIDTH-1:0] w_shift;
    logic                  w_complete;
    logic                  w_read;

    // Shift direction is fixed at elaboration: LSB-first enters at the top and
    // walks down, so the first bit ends up in bit 0 after DATA_WIDTH shifts.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shift = {serial_in, shreg_q[DATA_WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_shift = {shreg_q[DATA_WIDTH-2:0], serial_in};
        end
    endgenerate

    // A word completes on the ready edge that samples its last bit; a read is
    // any edge where the controller strobes Ei while a word is held.
    assign w_complete = ready & (cnt_q == c_LAST_BIT);
    assign w_read     = Ei & full_q;

    // Shift register and bit counter advance only on ready; gaps hold them.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (ready) begin
            shreg_d = w_shift;
            if (w_complete) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Holding register transfer: load when empty, swap when the held word is
    // read on the same edge, otherwise drop the new word and flag overrun.
    always_comb begin
        hold_d    = hold_q;
        full_d    = full_q;
        overrun_d = overrun_q;
        ack_d     = 1'b0;
        if (w_complete) begin
            if (!full_q) begin
                hold_d = w_shift;
                full_d = 1'b1;
            end else if (Ei) begin
                hold_d = w_shift;
                ack_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (w_read) begin
            // Hold keeps its value; it is simply no longer driven.
            full_d = 1'b0;
            ack_d  = 1'b1;
        end
    end

    // State registers with synchronous clear taking priority over everything.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            ack_q     <= ack_d;
        end
    end

    // Bus is driven only while the controller reads a held word.
    assign WBUS        = w_read ? hold_q : {DATA_WIDTH{1'bz}};
    assign full        = full_q;
    assign busy        = (cnt_q != '0);
    assign acknowledge = ack_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire
